// File: rtl/multi_button_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : multi_button_debouncer
// Description : N-channel push-button debouncer. Each channel synchronises a
//               raw pin, debounces it with a stability counter, and produces
//               a clean level plus press/release, long-press and auto-repeat
//               single-cycle pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_button_debouncer #(
    parameter int NUM_BTN       = 4,
    parameter int ACTIVE_LOW    = 1,
    parameter int CNT_WIDTH     = 16,
    parameter int HOLD_WIDTH    = 24,
    parameter int LONG_CYCLES   = 12_000_000,
    parameter int REPEAT_CYCLES = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] pb,
    output logic [NUM_BTN-1:0] pb_state,
    output logic [NUM_BTN-1:0] pb_down,
    output logic [NUM_BTN-1:0] pb_up,
    output logic [NUM_BTN-1:0] pb_long,
    output logic [NUM_BTN-1:0] pb_repeat
);

    // Long/repeat tracking states
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PRESSED = 2'd1;
    localparam logic [1:0] S_LONG    = 2'd2;

    // Debounce terminal count: the pin has differed for 2^CNT_WIDTH samples
    localparam logic [CNT_WIDTH-1:0]  c_cnt_max   = '1;
    localparam logic [HOLD_WIDTH-1:0] c_hold_max  = '1;
    // Pulses are registered, so the hit is detected one count early
    localparam logic [HOLD_WIDTH-1:0] c_long_last = HOLD_WIDTH'(LONG_CYCLES - 1);
    localparam logic [HOLD_WIDTH-1:0] c_rep_last  =
        HOLD_WIDTH'((REPEAT_CYCLES > 0) ? (REPEAT_CYCLES - 1) : 0);
    localparam logic                  c_repeat_en = (REPEAT_CYCLES > 0);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_chan
            logic                  w_raw;
            logic                  r_s0;
            logic                  r_s1;
            logic [CNT_WIDTH-1:0]  r_cnt;
            logic                  r_state;
            logic                  w_idle;
            logic                  w_toggle;
            logic                  w_rise;
            logic                  w_fall;
            logic                  r_down;
            logic                  r_up;
            logic                  r_long;
            logic                  r_repeat;
            logic [1:0]            r_fsm;
            logic [1:0]            w_fsm_next;
            logic [HOLD_WIDTH-1:0] r_hold;
            logic [HOLD_WIDTH-1:0] w_hold_next;
            logic                  w_long_hit;
            logic                  w_rep_hit;

            // Normalise polarity so that 1 always means pushed
            assign w_raw = (ACTIVE_LOW != 0) ? ~pb[gi] : pb[gi];

            // Two-flop synchroniser for the asynchronous pin
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_s0 <= 1'b0;
                    r_s1 <= 1'b0;
                end else begin
                    r_s0 <= w_raw;
                    r_s1 <= r_s0;
                end
            end

            // Accept a new level only after it has been seen without a break
            // for the full counter range; any return to idle restarts counting
            assign w_idle   = (r_s1 == r_state);
            assign w_toggle = ~w_idle & (r_cnt == c_cnt_max);
            assign w_rise   = w_toggle & ~r_state;
            assign w_fall   = w_toggle &  r_state;

            // Debounce counter and debounced level
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt   <= '0;
                    r_state <= 1'b0;
                end else if (w_idle) begin
                    r_cnt   <= '0;
                end else if (r_cnt == c_cnt_max) begin
                    r_cnt   <= '0;
                    r_state <= ~r_state;
                end else begin
                    r_cnt   <= r_cnt + 1'b1;
                end
            end

            // Press/release pulses, aligned with the first cycle of the new level
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_down <= 1'b0;
                    r_up   <= 1'b0;
                end else begin
                    r_down <= w_rise;
                    r_up   <= w_fall;
                end
            end

            // Long/repeat next-state and hold counter update
            always_comb begin
                w_fsm_next  = r_fsm;
                w_hold_next = r_hold;
                w_long_hit  = 1'b0;
                w_rep_hit   = 1'b0;

                if (!r_state) begin
                    w_hold_next = '0;
                end else if (r_hold != c_hold_max) begin
                    w_hold_next = r_hold + 1'b1;
                end

                // A release always wins, so no long/repeat pulse can share a
                // cycle with the release pulse
                case (r_fsm)
                    S_IDLE: begin
                        if (w_rise) begin
                            w_fsm_next = S_PRESSED;
                        end
                    end
                    S_PRESSED: begin
                        if (w_fall) begin
                            w_fsm_next  = S_IDLE;
                            w_hold_next = '0;
                        end else if (r_hold == c_long_last) begin
                            w_fsm_next  = S_LONG;
                            w_long_hit  = 1'b1;
                            w_hold_next = '0;
                        end
                    end
                    S_LONG: begin
                        if (w_fall) begin
                            w_fsm_next  = S_IDLE;
                            w_hold_next = '0;
                        end else if (c_repeat_en && (r_hold == c_rep_last)) begin
                            w_rep_hit   = 1'b1;
                            w_hold_next = '0;
                        end
                    end
                    default: begin
                        w_fsm_next  = S_IDLE;
                        w_hold_next = '0;
                    end
                endcase
            end

            // Long/repeat state register and hold counter
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_fsm  <= S_IDLE;
                    r_hold <= '0;
                end else begin
                    r_fsm  <= w_fsm_next;
                    r_hold <= w_hold_next;
                end
            end

            // Registered long-press and repeat pulses
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_long   <= 1'b0;
                    r_repeat <= 1'b0;
                end else begin
                    r_long   <= w_long_hit;
                    r_repeat <= w_rep_hit;
                end
            end

            assign pb_state[gi]  = r_state;
            assign pb_down[gi]   = r_down;
            assign pb_up[gi]     = r_up;
            assign pb_long[gi]   = r_long;
            assign pb_repeat[gi] = r_repeat;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_multi_button_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_button_debouncer
// Description : Self-checking bench for multi_button_debouncer. Directed
//               scenarios plus random pin activity, compared every cycle to
//               a behavioural model built from run lengths and press age.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_button_debouncer;

    localparam int NB      = 2;
    localparam int CNT_W   = 4;
    localparam int HOLD_W  = 8;
    localparam int LONG_C  = 20;
    localparam int REP_C   = 5;
    localparam int STABLE  = 1 << CNT_W;   // samples needed to accept a level
    localparam int LAT     = STABLE + 2;   // edges from pin change to new level

    logic          clk;
    logic          rst;
    logic [NB-1:0] pb;
    logic [NB-1:0] pb_state;
    logic [NB-1:0] pb_down;
    logic [NB-1:0] pb_up;
    logic [NB-1:0] pb_long;
    logic [NB-1:0] pb_repeat;

    int total;
    int bad;

    multi_button_debouncer #(
        .NUM_BTN       (NB),
        .ACTIVE_LOW    (1),
        .CNT_WIDTH     (CNT_W),
        .HOLD_WIDTH    (HOLD_W),
        .LONG_CYCLES   (LONG_C),
        .REPEAT_CYCLES (REP_C)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pb        (pb),
        .pb_state  (pb_state),
        .pb_down   (pb_down),
        .pb_up     (pb_up),
        .pb_long   (pb_long),
        .pb_repeat (pb_repeat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Pin history delayed by two samples, a run length of disagreeing
    // samples, and the number of cycles since the press was accepted.
    bit m_d0  [NB];
    bit m_d1  [NB];
    bit m_st  [NB];
    int m_run [NB];
    int m_age [NB];
    logic [NB-1:0] e_state, e_down, e_up, e_long, e_rep;

    task automatic model_reset();
        for (int c = 0; c < NB; c++) begin
            m_d0[c]  = 1'b0;
            m_d1[c]  = 1'b0;
            m_st[c]  = 1'b0;
            m_run[c] = 0;
            m_age[c] = 0;
        end
        e_state = '0; e_down = '0; e_up = '0; e_long = '0; e_rep = '0;
    endtask

    task automatic model_step();
        bit seen;
        if (rst) begin
            model_reset();
            return;
        end
        e_down = '0; e_up = '0; e_long = '0; e_rep = '0;
        for (int c = 0; c < NB; c++) begin
            seen     = m_d1[c];
            m_d1[c]  = m_d0[c];
            m_d0[c]  = ~pb[c];
            m_run[c] = (seen != m_st[c]) ? m_run[c] + 1 : 0;
            if (m_run[c] == STABLE) begin
                m_st[c]  = ~m_st[c];
                m_run[c] = 0;
                m_age[c] = 0;
                if (m_st[c]) e_down[c] = 1'b1;
                else         e_up[c]   = 1'b1;
            end else if (m_st[c]) begin
                m_age[c] = m_age[c] + 1;
                if (m_age[c] == LONG_C)
                    e_long[c] = 1'b1;
                else if (REP_C > 0 && m_age[c] > LONG_C && ((m_age[c] - LONG_C) % REP_C) == 0)
                    e_rep[c] = 1'b1;
            end
            e_state[c] = m_st[c];
        end
    endtask

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic compare_all();
        logic [NB-1:0] w_mix;
        check_val("pb_state",  32'(pb_state),  32'(e_state));
        check_val("pb_down",   32'(pb_down),   32'(e_down));
        check_val("pb_up",     32'(pb_up),     32'(e_up));
        check_val("pb_long",   32'(pb_long),   32'(e_long));
        check_val("pb_repeat", 32'(pb_repeat), 32'(e_rep));
        w_mix = (pb_down & pb_up) | (pb_down & pb_long) | (pb_down & pb_repeat) |
                (pb_up & pb_long) | (pb_up & pb_repeat) | (pb_long & pb_repeat);
        check_val("pulse_excl", 32'(w_mix), 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Counts edges until channel ch reads pushed; 0 if it never does
    task automatic wait_state(input int ch, input int limit, output int n);
        n = 0;
        for (int k = 1; k <= limit; k++) begin
            tick();
            if (pb_state[ch] && n == 0) begin
                n = k;
                break;
            end
        end
    endtask

    // ---------------- stimulus ----------------
    int n;
    int rem [NB];
    bit lvl [NB];

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        pb    = '1;
        model_reset();
        #1;
        check_val("rst_state", 32'(pb_state), 32'd0);
        check_val("rst_down",  32'(pb_down),  32'd0);
        ticks(3);
        rst = 1'b0;

        // Clean press on channel 0, held long enough for long + repeats
        ticks(4);
        pb[0] = 1'b0;
        wait_state(0, 40, n);
        check_val("press_lat", 32'(n), 32'(LAT));
        ticks(50);
        pb[0] = 1'b1;
        ticks(30);

        // Bounce then a short press
        pb[0] = 1'b0; ticks(10);
        pb[0] = 1'b1; ticks(3);
        pb[0] = 1'b0;
        wait_state(0, 40, n);
        check_val("bounce_lat", 32'(n), 32'(LAT));
        ticks(10);
        pb[0] = 1'b1;
        ticks(30);

        // Both channels pressed in the same cycle
        pb = 2'b00;
        n  = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (pb_down != '0) begin
                n = k;
                break;
            end
        end
        check_val("simul_down", 32'(pb_down), 32'b11);
        check_val("simul_lat",  32'(n),       32'(LAT));
        ticks(5);

        // Asynchronous reset between edges while held
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_val("arst_state",  32'(pb_state),  32'd0);
        check_val("arst_down",   32'(pb_down),   32'd0);
        check_val("arst_up",     32'(pb_up),     32'd0);
        check_val("arst_long",   32'(pb_long),   32'd0);
        check_val("arst_repeat", 32'(pb_repeat), 32'd0);
        ticks(2);
        rst = 1'b0;
        wait_state(0, 40, n);
        check_val("rerise_lat", 32'(n), 32'(LAT));
        ticks(30);
        pb = 2'b11;
        ticks(30);

        // Random activity: mixes of glitches and long holds per channel
        for (int c = 0; c < NB; c++) begin
            lvl[c] = 1'b0;
            rem[c] = $urandom_range(1, 30);
        end
        for (int k = 0; k < 2500; k++) begin
            for (int c = 0; c < NB; c++) begin
                if (rem[c] == 0) begin
                    lvl[c] = ~lvl[c];
                    rem[c] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 14)
                                                         : $urandom_range(20, 70);
                end
                pb[c]  = ~lvl[c];
                rem[c] = rem[c] - 1;
            end
            tick();
        end
        pb = 2'b11;
        ticks(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
